// File: rtl/gpu_dispatch_pkg.sv
// Shared definitions for the thread dispatcher: opcode and FSM state
// encodings plus the bit positions of every field in an instruction word.
package gpu_dispatch_pkg;

  // Instruction opcodes as seen by the functional-unit lanes.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_FADD = 3'b100,
    OP_FSUB = 3'b101,
    OP_LOAD = 3'b110,
    OP_END  = 3'b111
  } opcode_e;

  // Dispatcher FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Instruction word layout; bits [7:0] carry nothing for the lanes.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;
  localparam int DST_MSB = 28;
  localparam int DST_LSB = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 19;
  localparam int RS2_MSB = 18;
  localparam int RS2_LSB = 14;
  localparam int SHM_MSB = 13;
  localparam int SHM_LSB = 8;

  // Decoded view of one instruction word.
  typedef struct packed {
    opcode_e    opcode;
    logic [4:0] dest_reg;
    logic [4:0] regnum_1;
    logic [4:0] regnum_2;
    logic [5:0] shammt;
  } instr_fields_t;

endpackage

// File: rtl/thread_dispatch_if.sv
// Dispatcher-side bus: instruction-memory read channel plus the decoded
// instruction broadcast and completion flags shared with the lanes.
// The dispatcher connects through the master modport.
interface thread_dispatch_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 8
) ();

  logic                   imem_req;
  logic [PC_W-1:0]        imem_addr;
  logic                   imem_valid;
  logic [31:0]            imem_rdata;
  logic [2:0]             type_instruction;
  logic [4:0]             regnum_1;
  logic [4:0]             regnum_2;
  logic [4:0]             dest_reg;
  logic [5:0]             shammt;
  logic [NUM_THREADS-1:0] is_active;
  logic [NUM_THREADS-1:0] thread_complete;

  modport master (
    output imem_req, imem_addr,
    output type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active,
    input  imem_valid, imem_rdata, thread_complete
  );

  modport slave (
    input  imem_req, imem_addr,
    input  type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active,
    output imem_valid, imem_rdata, thread_complete
  );

endinterface

// File: rtl/instr_decode.sv
// Pure combinational instruction decoder: splits a 32-bit instruction word
// into opcode and register/shift fields. The low byte is ignored.
module instr_decode
  import gpu_dispatch_pkg::*;
(
  input  logic [31:0]   word,
  output instr_fields_t fields
);

  // Low byte carries no information for the lanes.
  logic unused_low_bits;
  assign unused_low_bits = ^word[SHM_LSB-1:0];

  // Slice every field out of the word at its fixed position.
  always_comb begin
    fields          = '0;
    fields.opcode   = opcode_e'(word[OPC_MSB:OPC_LSB]);
    fields.dest_reg = word[DST_MSB:DST_LSB];
    fields.regnum_1 = word[RS1_MSB:RS1_LSB];
    fields.regnum_2 = word[RS2_MSB:RS2_LSB];
    fields.shammt   = word[SHM_MSB:SHM_LSB];
  end

endmodule

// File: rtl/thread_dispatch.sv
// Thread dispatcher: fetches one instruction at a time from instruction
// memory, broadcasts it for exactly one cycle to the participating lanes,
// and waits for all participating lanes to report completion after END.
// Optional build macro: THREAD_DISPATCH_PERF_EN enables the saturating
// issued-instruction counter on instr_count (tied to zero otherwise).
module thread_dispatch
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_W-1:0]        base_pc,
  input  logic [NUM_THREADS-1:0] thread_mask,
  thread_dispatch_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            instr_count
);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_FETCH = 3'(ST_FETCH);
  localparam logic [2:0] S_WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] S_ISSUE = 3'(ST_ISSUE);
  localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);

  logic [2:0]             state_reg;
  logic [PC_W-1:0]        pc_reg;
  logic [NUM_THREADS-1:0] mask_reg;
  logic [31:0]            instr_reg;
  logic                   error_reg;
  instr_fields_t          dec;
  logic                   in_issue;
  logic                   start_ok;
  logic                   lanes_done;

  assign in_issue   = (state_reg == S_ISSUE);
  assign start_ok   = (state_reg == S_IDLE) && start;
  assign lanes_done = ((bus.thread_complete & mask_reg) == mask_reg);

  instr_decode u_decode (
    .word   (instr_reg),
    .fields (dec)
  );

  // Main control FSM with kernel context (pc, lane mask, held instruction).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      mask_reg  <= '0;
      instr_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_FETCH;
            pc_reg    <= base_pc;
            mask_reg  <= thread_mask;
            error_reg <= 1'b0;
          end
        end
        S_FETCH: state_reg <= S_WAIT;
        S_WAIT: begin
          if (bus.imem_valid) begin
            instr_reg <= bus.imem_rdata;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dec.opcode == OP_END) begin
            state_reg <= S_DRAIN;
          end else if (pc_reg == '1) begin
            // Running off the top of instruction memory is a fault, not a wrap.
            error_reg <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            pc_reg    <= pc_reg + 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (lanes_done) state_reg <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef THREAD_DISPATCH_PERF_EN
  logic [15:0] count_reg;

  // Saturating count of ISSUE cycles, cleared when a kernel is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (start_ok) begin
      count_reg <= '0;
    end else if (in_issue && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign instr_count = count_reg;
`else
  assign instr_count = 16'd0;
`endif

  // Memory request, status, and the one-cycle decoded broadcast; every lane
  // output is forced to zero outside ISSUE so nothing is executed twice.
  always_comb begin
    bus.imem_req         = (state_reg == S_FETCH);
    bus.imem_addr        = (state_reg == S_FETCH) ? pc_reg : '0;
    bus.type_instruction = 3'b000;
    bus.dest_reg         = 5'd0;
    bus.regnum_1         = 5'd0;
    bus.regnum_2         = 5'd0;
    bus.shammt           = 6'd0;
    bus.is_active        = '0;
    if (in_issue) begin
      bus.type_instruction = dec.opcode;
      bus.dest_reg         = dec.dest_reg;
      bus.regnum_1         = dec.regnum_1;
      bus.regnum_2         = dec.regnum_2;
      bus.shammt           = dec.shammt;
      bus.is_active        = mask_reg;
    end
    busy  = (state_reg != S_IDLE);
    done  = (state_reg == S_DONE);
    error = error_reg;
  end

endmodule

// File: doc/thread_dispatch.md
THREAD_DISPATCH -- requirements
Module: thread_dispatch

Interface
REQ-001 Parameter NUM_THREADS, default 4, number of functional-unit lanes driven.
REQ-002 Parameter PC_W, default 8, instruction-memory address width.
REQ-003 clk  input  1  clock; all state updates on posedge (functional units sample on negedge).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse to begin a kernel at base_pc.
REQ-006 base_pc  input  PC_W  first instruction address.
REQ-007 thread_mask  input  NUM_THREADS  lanes participating in the kernel; sampled on accepted start.
REQ-008 imem_req  output  1  instruction read request, one-cycle pulse.
REQ-009 imem_addr  output  PC_W  read address, valid with imem_req.
REQ-010 imem_valid  input  1  read data valid, arbitrary latency >= 1 cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 type_instruction  output  3  decoded opcode to lanes.
REQ-013 regnum_1, regnum_2, dest_reg  output  5 each  decoded register indices.
REQ-014 shammt  output  6  decoded shift amount.
REQ-015 is_active  output  NUM_THREADS  per-lane execute enable.
REQ-016 thread_complete  input  NUM_THREADS  per-lane completion flags.
REQ-017 busy  output  1  high from accepted start until done.
REQ-018 done  output  1  one-cycle pulse at kernel end.
REQ-019 error  output  1  sticky fault flag, cleared by next accepted start or rst.
REQ-020 instr_count  output  16  issued-instruction count (see Configuration).

Function
REQ-021 Encoding: [31:29] opcode, [28:24] dest_reg, [23:19] regnum_1, [18:14] regnum_2, [13:8] shammt, [7:0] ignored.
REQ-022 Opcodes 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 FADD, 101 FSUB, 110 LOAD (register file init), 111 END.
REQ-023 FSM states IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE.
REQ-024 IDLE: start -> FETCH, pc <= base_pc, mask <= thread_mask, error <= 0, instr_count <= 0; start outside IDLE ignored.
REQ-025 FETCH: imem_req=1, imem_addr=pc for exactly one cycle -> WAIT.
REQ-026 WAIT: hold until imem_valid, latch imem_rdata into instr register -> ISSUE; imem_valid in any other state ignored.
REQ-027 ISSUE: one cycle; decoded fields driven from instr register; is_active = mask; instr_count increments.
REQ-028 ISSUE with opcode != END: pc <= pc+1 -> FETCH; if pc == all-ones -> error <= 1, DONE (no wrap).
REQ-029 ISSUE with END -> DRAIN.
REQ-030 Outside ISSUE: is_active = 0, decoded outputs = 0, so lanes never re-execute a held instruction.
REQ-031 DRAIN: wait until (thread_complete & mask) == mask -> DONE; mask == 0 completes on first DRAIN cycle.
REQ-032 DONE: done=1 one cycle -> IDLE; busy=0 in IDLE, 1 in all other states.
REQ-033 Minimum per-instruction cost 3 cycles (FETCH, WAIT with 1-cycle latency, ISSUE).

Reset
REQ-034 rst forces IDLE asynchronously, mid-kernel included; pending memory read discarded.
REQ-035 Reset values: imem_req 0, imem_addr 0, all decoded outputs 0, is_active 0, busy 0, done 0, error 0, instr_count 0, pc 0, mask 0.

Configuration
REQ-036 Macro THREAD_DISPATCH_PERF_EN: defined -> instr_count counts ISSUE cycles, saturating at 16'hFFFF; undefined -> counter not built, instr_count tied 0; port always present.

Structure
REQ-037 Package gpu_dispatch_pkg holds opcode enum, FSM state enum, instruction field bit-position constants.
REQ-038 Sub-module instr_decode: combinational, 32-bit word in, opcode/fields out; the only decode logic.

Verification
REQ-039 start, base_pc=0x10, mask=4'b1111, mem {0x10: ADD d=3 r1=1 r2=2, 0x11: END}, 1-cycle latency -> imem_addr 0x10 then 0x11, ADD issue with is_active=1111 for one cycle, done after all thread_complete high, instr_count=2 (PERF_EN).
REQ-040 mask=4'b0101, thread_complete lanes 0,2 high, lanes 1,3 low -> done still asserted; is_active never 1 on lanes 1,3.
REQ-041 imem latency 5 cycles -> WAIT held 5 cycles, is_active 0 throughout, no extra imem_req.
REQ-042 base_pc=0xFF, non-END at 0xFF -> error=1, done pulse, no fetch at 0x00.
REQ-043 rst asserted during WAIT, stray imem_valid afterwards -> IDLE, all outputs 0, no issue.
REQ-044 start pulsed while busy -> ignored, kernel completes unchanged.
